// File: rtl/safety_check_sched_if.sv
`default_nettype none
// ============================================================================
// Module   : safety_check_sched_if
// Brief    : Sample/clear bus between the register banks, host and the
//            current-error supervisor. Adds warn when SAFETY_SCHED_WARN_EN.
// Revision : 1.0 - initial release
// ============================================================================
interface safety_check_sched_if #(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 16
);
  localparam int c_idx_w = $clog2(NUM_CH);

  logic [NUM_CH*DATA_W-1:0] cur_in;
  logic [NUM_CH*DATA_W-1:0] dac_in;
  logic [NUM_CH-1:0]        ch_enable;
  logic                     clr_req;
  logic [NUM_CH-1:0]        clr_mask;
  logic                     clr_ack;
  logic [NUM_CH-1:0]        amp_disable;
  logic [c_idx_w-1:0]       ch_idx;
`ifdef SAFETY_SCHED_WARN_EN
  logic [NUM_CH-1:0]        warn;

  modport master (
    output cur_in, dac_in, ch_enable, clr_req, clr_mask,
    input  clr_ack, amp_disable, ch_idx, warn
  );
  modport slave (
    input  cur_in, dac_in, ch_enable, clr_req, clr_mask,
    output clr_ack, amp_disable, ch_idx, warn
  );
`else
  modport master (
    output cur_in, dac_in, ch_enable, clr_req, clr_mask,
    input  clr_ack, amp_disable, ch_idx
  );
  modport slave (
    input  cur_in, dac_in, ch_enable, clr_req, clr_mask,
    output clr_ack, amp_disable, ch_idx
  );
`endif
endinterface
`default_nettype wire

// File: rtl/safety_check_sched.sv
`default_nettype none
// ============================================================================
// Module   : safety_check_sched
// Brief    : Round-robin current-error supervisor sharing one |cur-dac|
//            datapath across NUM_CH channels; sticky per-channel faults with
//            host clear handshake. Option macro: SAFETY_SCHED_WARN_EN.
// Revision : 1.0 - initial release
// ============================================================================
module safety_check_sched #(
  parameter int NUM_CH     = 4,
  parameter int DATA_W     = 16,
  parameter int ERR_LIMIT  = 16'h1200,
  parameter int CNT_W      = 24,
  parameter int TRIP_COUNT = 614400
) (
  input  logic               clk,
  input  logic               reset,
  safety_check_sched_if.slave bus
);

  localparam int                 c_idx_w     = $clog2(NUM_CH);
  localparam logic [c_idx_w-1:0] c_last_ch   = c_idx_w'(NUM_CH - 1);
  localparam logic [c_idx_w-1:0] c_idx_one   = c_idx_w'(1);
  localparam logic [DATA_W-1:0]  c_err_limit = DATA_W'(ERR_LIMIT);
  localparam logic [CNT_W-1:0]   c_cnt_max   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0]   c_cnt_one   = CNT_W'(1);
  localparam logic [CNT_W-1:0]   c_trip      = CNT_W'(TRIP_COUNT);
`ifdef SAFETY_SCHED_WARN_EN
  localparam logic [CNT_W-1:0]   c_warn      = CNT_W'(TRIP_COUNT / 2);
`endif

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_CLEAR = 2'd1,
    ST_ACK   = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;
  logic   w_scan;
  logic   w_do_clear;

  logic [c_idx_w-1:0] r_ch_idx;
  logic [NUM_CH-1:0]  r_mask;
  logic               r_s0_valid;
  logic [c_idx_w-1:0] r_s0_tag;
  logic [DATA_W-1:0]  r_s0_cur;
  logic [DATA_W-1:0]  r_s0_dac;
  logic               r_s1_valid;
  logic [c_idx_w-1:0] r_s1_tag;
  logic [DATA_W-1:0]  r_s1_err;
  logic [DATA_W-1:0]  w_abs_err;
  logic               w_s2_upd;

  always_ff @(posedge clk) begin
    if (!reset) r_state <= ST_RUN;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_scan      = 1'b0;
    w_do_clear  = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (bus.clr_req) w_state_nxt = ST_CLEAR;
        else             w_scan      = 1'b1;
      end
      ST_CLEAR: begin
        w_do_clear  = 1'b1;
        w_state_nxt = ST_ACK;
      end
      ST_ACK: begin
        if (!bus.clr_req) w_state_nxt = ST_RUN;
      end
      default: w_state_nxt = ST_RUN;
    endcase
  end

  assign w_abs_err = (r_s0_cur > r_s0_dac) ? (r_s0_cur - r_s0_dac) : (r_s0_dac - r_s0_cur);
  // Leaving RUN kills in-flight samples, so a clear never races a counter update.
  assign w_s2_upd  = r_s1_valid & w_scan;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_ch_idx   <= '0;
      r_mask     <= '0;
      r_s0_valid <= 1'b0;
      r_s0_tag   <= '0;
      r_s0_cur   <= '0;
      r_s0_dac   <= '0;
      r_s1_valid <= 1'b0;
      r_s1_tag   <= '0;
      r_s1_err   <= '0;
    end else begin
      r_s0_valid <= w_scan;
      r_s1_valid <= r_s0_valid & w_scan;
      r_s1_tag   <= r_s0_tag;
      r_s1_err   <= w_abs_err;
      if (w_scan) begin
        r_s0_tag <= r_ch_idx;
        r_s0_cur <= bus.cur_in[r_ch_idx*DATA_W +: DATA_W];
        r_s0_dac <= bus.dac_in[r_ch_idx*DATA_W +: DATA_W];
        r_ch_idx <= (r_ch_idx == c_last_ch) ? '0 : (r_ch_idx + c_idx_one);
      end
      if (w_do_clear) r_ch_idx <= '0;
      if ((r_state == ST_RUN) && bus.clr_req) r_mask <= bus.clr_mask;
    end
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    logic [CNT_W-1:0] r_cnt;
    logic             r_fault;
    logic             r_amp;
    logic [CNT_W-1:0] w_cnt_inc;
    logic [CNT_W-1:0] w_cnt_new;
    logic             w_hit;
    logic             w_trip;
    logic             w_clr;

    assign w_hit     = w_s2_upd && (r_s1_tag == c_idx_w'(k));
    assign w_clr     = w_do_clear & r_mask[k];
    assign w_cnt_inc = (r_cnt == c_cnt_max) ? r_cnt : (r_cnt + c_cnt_one);
    assign w_cnt_new = (bus.ch_enable[k] && (r_s1_err > c_err_limit)) ? w_cnt_inc : '0;
    assign w_trip    = bus.ch_enable[k] && (w_cnt_new >= c_trip);

`ifdef SAFETY_SCHED_WARN_EN
    logic r_warn;
    always_ff @(posedge clk) begin
      if (!reset || w_clr)  r_warn <= 1'b0;
      else if (w_hit)       r_warn <= (w_cnt_new >= c_warn) && !(r_fault || w_trip);
    end
    assign bus.warn[k] = r_warn;
`endif

    always_ff @(posedge clk) begin
      if (!reset) begin
        r_cnt   <= '0;
        r_fault <= 1'b0;
        r_amp   <= 1'b0;
      end else begin
        // The amplifier output lags the fault by one edge, except a clear drops both together.
        r_amp <= r_fault & ~w_clr;
        if (w_clr) begin
          r_cnt   <= '0;
          r_fault <= 1'b0;
        end else if (w_hit) begin
          r_cnt   <= w_cnt_new;
          r_fault <= r_fault | w_trip;
        end
      end
    end

    assign bus.amp_disable[k] = r_amp;
  end

  assign bus.ch_idx  = r_ch_idx;
  assign bus.clr_ack = (r_state == ST_ACK);

endmodule
`default_nettype wire

// File: tb/tb_safety_check_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_safety_check_sched
// Brief    : Directed self-checking bench for safety_check_sched (TRIP_COUNT=5).
// Revision : 1.0 - initial release
// ============================================================================
module tb_safety_check_sched;

  localparam int NUM_CH = 4;
  localparam int DATA_W = 16;
  localparam int CNT_W  = 24;
  localparam int TRIP   = 5;

  logic clk = 1'b0;
  logic reset;
  int   n_tests = 0;
  int   n_fail  = 0;

  safety_check_sched_if #(.NUM_CH(NUM_CH), .DATA_W(DATA_W)) bus();

  safety_check_sched #(
    .NUM_CH    (NUM_CH),
    .DATA_W    (DATA_W),
    .ERR_LIMIT (16'h1200),
    .CNT_W     (CNT_W),
    .TRIP_COUNT(TRIP)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_ch(input int k, input logic [15:0] cur, input logic [15:0] dac);
    bus.cur_in[k*DATA_W +: DATA_W] = cur;
    bus.dac_in[k*DATA_W +: DATA_W] = dac;
  endtask

  task automatic wait_idx(input int k);
    int n = 0;
    while (32'(bus.ch_idx) != k && n < 16) begin
      tick(1);
      n++;
    end
    check("wait_idx", 32'(bus.ch_idx), k);
  endtask

  // Returns at the negedge just after the n-th further capture of channel k.
  task automatic run_samples(input int k, input int n);
    repeat (n) begin
      wait_idx(k);
      tick(1);
    end
  endtask

  initial begin
    reset         = 1'b0;
    bus.cur_in    = '0;
    bus.dac_in    = '0;
    bus.ch_enable = '1;
    bus.clr_req   = 1'b0;
    bus.clr_mask  = '0;
    tick(3);
    check("rst_amp", 32'(bus.amp_disable), 0);
    check("rst_ack", 32'(bus.clr_ack), 0);
    check("rst_idx", 32'(bus.ch_idx), 0);

    for (int k = 0; k < NUM_CH; k++) set_ch(k, 16'h0400 + 16'(k * 16'h111), 16'h0400 + 16'(k * 16'h111));
    reset = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      tick(1);
      check("scan_idx", 32'(bus.ch_idx), i % NUM_CH);
    end
    tick(32);
    check("equal_no_trip", 32'(bus.amp_disable), 0);

    // ch2 error 0x1201: trips three edges after its fifth capture
    wait_idx(3);
    set_ch(2, 16'h3000, 16'h1DFF);
    run_samples(2, 4);
    wait_idx(2);
    check("ch2_before_c5", 32'(bus.amp_disable), 0);
`ifdef SAFETY_SCHED_WARN_EN
    check("ch2_warn_up", 32'(bus.warn), 32'h4);
`endif
    tick(1);
    check("ch2_c5_e1", 32'(bus.amp_disable), 0);
    tick(1);
    check("ch2_c5_e2", 32'(bus.amp_disable), 0);
    tick(1);
    check("ch2_c5_e3_fault_only", 32'(bus.amp_disable), 0);
`ifdef SAFETY_SCHED_WARN_EN
    check("ch2_warn_down", 32'(bus.warn), 0);
`endif
    tick(1);
    check("ch2_tripped", 32'(bus.amp_disable), 32'h4);

    // ch1 exactly at the limit never counts; a single good sample resets the count
    set_ch(1, 16'h1300, 16'h0100);
    run_samples(1, 8);
    tick(4);
    check("ch1_at_limit", 32'(bus.amp_disable), 32'h4);
    set_ch(1, 16'h0000, 16'h1201);
    run_samples(1, 4);
    set_ch(1, 16'h0200, 16'h0200);
    run_samples(1, 1);
    set_ch(1, 16'h0000, 16'h1201);
    run_samples(1, 4);
    set_ch(1, 16'h0200, 16'h0200);
    tick(4);
    check("ch1_count_reset", 32'(bus.amp_disable), 32'h4);

    // Fresh start: trip ch0 and ch3, then clear ch0 only
    reset = 1'b0;
    for (int k = 0; k < NUM_CH; k++) set_ch(k, 16'h0100, 16'h0100);
    tick(2);
    check("rst2_amp", 32'(bus.amp_disable), 0);
    reset = 1'b1;
    set_ch(0, 16'h0000, 16'h2000);
    set_ch(3, 16'hFFFF, 16'h0000);
    tick(30);
    check("trip_ch0_ch3", 32'(bus.amp_disable), 32'h9);
    set_ch(0, 16'h0100, 16'h0100);
    set_ch(3, 16'h0100, 16'h0100);
    tick(8);
    check("sticky_ch0_ch3", 32'(bus.amp_disable), 32'h9);

    bus.clr_req  = 1'b1;
    bus.clr_mask = 4'b0001;
    tick(1);
    check("clear_state_ack", 32'(bus.clr_ack), 0);
    tick(1);
    check("ack_high", 32'(bus.clr_ack), 1);
    check("ack_amp", 32'(bus.amp_disable), 32'h8);
    check("ack_idx", 32'(bus.ch_idx), 0);
    bus.clr_mask = 4'b1000;
    tick(5);
    check("ack_held", 32'(bus.clr_ack), 1);
    check("single_clear_amp", 32'(bus.amp_disable), 32'h8);
    check("ack_stall_idx", 32'(bus.ch_idx), 0);
    bus.clr_req = 1'b0;
    tick(1);
    check("ack_drop", 32'(bus.clr_ack), 0);
    check("restart_idx0", 32'(bus.ch_idx), 0);
    tick(1);
    check("restart_idx1", 32'(bus.ch_idx), 1);
    tick(8);
    check("post_clear_amp", 32'(bus.amp_disable), 32'h8);

    // Disabled channel never counts; after re-enable it trips after TRIP samples
    bus.ch_enable[1] = 1'b0;
    set_ch(1, 16'hFFFF, 16'h0000);
    run_samples(1, 100);
    check("disabled_no_trip", 32'(bus.amp_disable), 32'h8);
    tick(2);
    bus.ch_enable[1] = 1'b1;
    run_samples(1, 4);
    check("reen_c4", 32'(bus.amp_disable), 32'h8);
    run_samples(1, 1);
    tick(2);
    check("reen_c5_e2", 32'(bus.amp_disable), 32'h8);
    tick(1);
    check("reen_tripped", 32'(bus.amp_disable), 32'hA);

    // Reset while in ACK
    bus.clr_req  = 1'b1;
    bus.clr_mask = 4'b0000;
    tick(2);
    check("ack_before_rst", 32'(bus.clr_ack), 1);
    check("ack_amp_kept", 32'(bus.amp_disable), 32'hA);
    reset = 1'b0;
    tick(1);
    check("rst_ack_drop", 32'(bus.clr_ack), 0);
    check("rst_ack_amp", 32'(bus.amp_disable), 0);
    check("rst_ack_idx", 32'(bus.ch_idx), 0);
    reset       = 1'b1;
    bus.clr_req = 1'b0;
    tick(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
